// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
// Two-entry skid buffer for a valid/ready pipeline. It accepts and delivers
// one entry per clock when downstream is ready. in_ready is decoded from the
// registered state only, so there is no combinational path from in_valid or
// out_ready back to in_ready. The second register (skid) absorbs the entry
// that arrives in the same cycle downstream stalls.
//
// State table
//   state | meaning
//   EMPTY | no entry held
//   ONE   | main valid, skid unused
//   TWO   | main and skid valid, in_ready low
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset (wins over flush)
//   flush      synchronous discard of all held entries
//   in_valid   upstream presents in_data
//   in_ready   stage can accept an entry this cycle
//   in_data    upstream payload [DATA_W]
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts out_data this cycle
//   out_data   head payload, driven straight from the main register
//   occupancy  number of held entries (0..2)
//   hold_cnt   saturating count of cycles with out_valid & ~out_ready
module pipe_skid_stage #(
    parameter int DATA_W        = 64,
    parameter bit ZERO_ON_FLUSH = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  hold_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] cntMax = '1;

    state_t            state;
    state_t            stateNext;
    logic [DATA_W-1:0] mainReg;
    logic [DATA_W-1:0] mainNext;
    logic [DATA_W-1:0] skidReg;
    logic [DATA_W-1:0] skidNext;
    logic [CNT_W-1:0]  holdCnt;
    logic              inXfer;
    logic              outXfer;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = mainReg;
    assign hold_cnt  = holdCnt;
    assign inXfer    = in_valid & in_ready;
    assign outXfer   = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        stateNext = state;
        mainNext  = mainReg;
        skidNext  = skidReg;
        case (state)
            EMPTY: begin
                if (inXfer) begin
                    stateNext = ONE;
                    mainNext  = in_data;
                end
            end
            ONE: begin
                if (inXfer && outXfer) begin
                    mainNext = in_data;
                end else if (inXfer) begin
                    stateNext = TWO;
                    skidNext  = in_data;
                end else if (outXfer) begin
                    stateNext = EMPTY;
                end
            end
            TWO: begin
                if (outXfer) begin
                    stateNext = ONE;
                    mainNext  = skidReg;
                end
            end
            default: stateNext = EMPTY;
        endcase

        // Flush overrides every transition; any input in this cycle is lost,
        // while an output transfer in this cycle has already been consumed.
        if (flush) begin
            stateNext = EMPTY;
            if (ZERO_ON_FLUSH) begin
                mainNext = '0;
                skidNext = '0;
            end else begin
                mainNext = mainReg;
                skidNext = skidReg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            mainReg <= '0;
            skidReg <= '0;
        end else begin
            state   <= stateNext;
            mainReg <= mainNext;
            skidReg <= skidNext;
        end
    end

    // Only rst clears the stall counter; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            holdCnt <= '0;
        end else if (out_valid && !out_ready && (holdCnt != cntMax)) begin
            holdCnt <= holdCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage. Two instances share all inputs: dutA zeroes on
// flush with a 3-bit counter, dutB keeps payload on flush with a 16-bit
// counter. The reference model is a plain queue of held entries (at most 2);
// the driver pushes accepted entries into it and clears it on flush/rst, and
// the negedge monitor pops it on every output transfer and compares.
module tb_pipe_skid_stage;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          inReadyA, outValidA, inReadyB, outValidB;
    logic [DW-1:0] outDataA, outDataB;
    logic [1:0]    occA, occB;
    logic [2:0]    holdA;
    logic [15:0]   holdB;

    pipe_skid_stage #(.DATA_W(DW), .ZERO_ON_FLUSH(1'b1), .CNT_W(3)) dutA (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(inReadyA), .in_data(in_data),
        .out_valid(outValidA), .out_ready(out_ready), .out_data(outDataA),
        .occupancy(occA), .hold_cnt(holdA)
    );

    pipe_skid_stage #(.DATA_W(DW), .ZERO_ON_FLUSH(1'b0), .CNT_W(16)) dutB (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(inReadyB), .in_data(in_data),
        .out_valid(outValidB), .out_ready(out_ready), .out_data(outDataB),
        .occupancy(occB), .hold_cnt(holdB)
    );

    int            nChecks = 0;
    int            nFail   = 0;
    int            nOut    = 0;
    int            hA      = 0;
    int            hB      = 0;
    bit            monOn   = 1'b0;
    bit            zeroed  = 1'b0;
    logic [DW-1:0] mdl[$];
    logic [DW-1:0] seen[$];

    bit            pAcc, pFl, pRst, pHold;
    logic [DW-1:0] pData;

    function automatic void chk(string name, longint act, longint exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock: drive inputs, predict from the model state at cycle start,
    // then fold the cycle's effects into the model after the edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit o,
                        input bit f, input bit r);
        in_valid  = v;
        in_data   = d;
        out_ready = o;
        flush     = f;
        rst       = r;
        pAcc  = v && (mdl.size() < 2);
        pData = d;
        pFl   = f;
        pRst  = r;
        pHold = (mdl.size() > 0) && !o;
        @(posedge clk);
        #1;
        if (pRst) begin
            mdl.delete();
            hA = 0;
            hB = 0;
            zeroed = 1'b1;
        end else begin
            if (pFl) begin
                mdl.delete();
                zeroed = 1'b1;
            end else if (pAcc) begin
                mdl.push_back(pData);
                zeroed = 1'b0;
            end
            if (pHold) begin
                if (hA < 7) hA++;
                if (hB < 65535) hB++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            logic [DW-1:0] exp;
            chk("in_ready_a", inReadyA, mdl.size() < 2);
            chk("out_valid_a", outValidA, mdl.size() > 0);
            chk("occupancy_a", occA, mdl.size());
            chk("in_ready_b", inReadyB, mdl.size() < 2);
            chk("out_valid_b", outValidB, mdl.size() > 0);
            chk("hold_cnt_a", holdA, hA);
            chk("hold_cnt_b", holdB, hB);
            if (zeroed && mdl.size() == 0)
                chk("zeroed_data_a", outDataA, 0);
            if (outValidA && out_ready && mdl.size() > 0) begin
                exp = mdl.pop_front();
                chk("out_data_a", outDataA, exp);
                chk("out_data_b", outDataB, exp);
                seen.push_back(outDataA);
                nOut++;
            end
        end
    end

    initial begin
        int n0;
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        monOn = 1'b1;
        chk("rst_in_ready", inReadyA, 1);
        chk("rst_out_valid", outValidA, 0);
        chk("rst_out_data", outDataA, 0);
        chk("rst_occupancy", occA, 0);
        chk("rst_hold_cnt", holdA, 0);

        // streaming
        n0 = nOut;
        for (int i = 1; i <= 100; i++) begin
            step(1, DW'(i), 1, 0, 0);
            if (i == 1) begin
                chk("latency_valid", outValidA, 1);
                chk("latency_data", outDataA, 1);
            end
        end
        step(0, '0, 1, 0, 0);
        chk("stream_count", nOut - n0, 100);
        chk("stream_last", seen[seen.size()-1], 'h64);

        // backpressure
        n0 = nOut;
        step(1, DW'('hA), 0, 0, 0);
        step(1, DW'('hB), 0, 0, 0);
        chk("bp_occupancy", occA, 2);
        chk("bp_in_ready", inReadyA, 0);
        step(1, DW'('hC), 0, 0, 0);
        chk("bp_head", outDataA, 'hA);
        step(1, DW'('hC), 1, 0, 0);
        step(1, DW'('hC), 1, 0, 0);
        step(0, '0, 1, 0, 0);
        chk("bp_count", nOut - n0, 3);
        chk("bp_order0", seen[seen.size()-3], 'hA);
        chk("bp_order1", seen[seen.size()-2], 'hB);
        chk("bp_order2", seen[seen.size()-1], 'hC);

        // flush in TWO with an input offered
        step(1, DW'('hA), 0, 0, 0);
        step(1, DW'('hB), 0, 0, 0);
        step(1, DW'('hC), 0, 1, 0);
        n0 = nOut;
        chk("flush_occupancy", occA, 0);
        chk("flush_valid_a", outValidA, 0);
        chk("flush_data_a", outDataA, 0);
        chk("flush_valid_b", outValidB, 0);
        chk("flush_data_b", outDataB, 'hA);
        repeat (3) step(0, '0, 1, 0, 0);
        chk("flush_no_emit", nOut - n0, 0);

        // counter saturation
        step(0, '0, 0, 0, 1);
        step(1, DW'(5), 0, 0, 0);
        repeat (12) step(0, '0, 0, 0, 0);
        chk("sat_hold_a", holdA, 7);
        chk("sat_hold_b", holdB, 12);
        step(0, '0, 0, 1, 0);
        chk("sat_flush_a", holdA, 7);
        chk("sat_flush_b", holdB, 13);
        step(0, '0, 0, 0, 1);
        chk("sat_rst_a", holdA, 0);
        chk("sat_rst_b", holdB, 0);

        // rst while in TWO
        step(1, DW'(1), 0, 0, 0);
        step(1, DW'(2), 0, 0, 0);
        chk("rst2_occ_before", occA, 2);
        step(0, '0, 0, 0, 1);
        n0 = nOut;
        chk("rst2_valid", outValidA, 0);
        chk("rst2_occ", occA, 0);
        repeat (3) step(0, '0, 1, 0, 0);
        chk("rst2_no_emit", nOut - n0, 0);

        // random traffic with occasional flush
        for (int i = 0; i < 20000; i++) begin
            step(1'($urandom % 2), DW'($urandom), 1'(($urandom % 4) != 0),
                 1'($urandom_range(0, 99) == 0), 0);
        end
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        chk("drain_valid", outValidA, 0);

        monOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
